// File: rtl/jk_bank_sequencer.sv
// Command sequencer for a bank of WIDTH JK flip-flops: load, toggle and
// multi-step up/down counting, with completion, wrap and abort status.
module jk_bank_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clockpulse,
  input  logic             clear,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [7:0]       cmd_count,
  input  logic             abort,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] jack,
  output logic [WIDTH-1:0] kilby,
  output logic             bank_preset,
  output logic             busy,
  output logic             done,
  output logic             wrapped,
  output logic             aborted,
  output logic [7:0]       steps_left
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RUN, S_DONE} state_t;

  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [1:0] OP_UP     = 2'b01;
  localparam logic [1:0] OP_DOWN   = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  state_t           r_state;
  logic             r_dn;
  logic [WIDTH-1:0] r_ej, r_ek;
  logic [7:0]       r_steps;
  logic             r_ready, r_busy, r_done, r_preset, r_wrapped, r_aborted;

  logic [WIDTH-1:0] w_t;
  logic             w_wrap;

  // Bit i toggles when every lower bit is 1 (up) or 0 (down); the carry out
  // of the top bit is exactly the wrap condition.
  always_comb begin : toggle_chain
    logic v_acc;
    v_acc = 1'b1;
    w_t   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_t[i] = v_acc;
      v_acc  = v_acc & (r_dn ? ~q[i] : q[i]);
    end
    w_wrap = v_acc;
  end

  always_ff @(posedge clockpulse or posedge clear) begin
    if (clear) begin
      r_state   <= S_IDLE;
      r_dn      <= 1'b0;
      r_ej      <= '0;
      r_ek      <= '0;
      r_steps   <= 8'd0;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_preset  <= 1'b0;
      r_wrapped <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (cmd_valid) begin
          r_wrapped <= 1'b0;
          r_aborted <= 1'b0;
          r_ready   <= 1'b0;
          r_steps   <= 8'd0;
          r_dn      <= (cmd_op == OP_DOWN);
          if (cmd_op == OP_LOAD || cmd_op == OP_TOGGLE) begin
            r_ej     <= cmd_data;
            r_ek     <= (cmd_op == OP_LOAD) ? ~cmd_data : cmd_data;
            r_state  <= S_EXEC;
            r_busy   <= 1'b1;
            r_preset <= 1'b1;
          end else if (cmd_count != 8'd0) begin
            r_steps  <= cmd_count;
            r_state  <= S_RUN;
            r_busy   <= 1'b1;
            r_preset <= 1'b1;
          end else begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_EXEC: begin
          r_ej     <= '0;
          r_ek     <= '0;
          r_state  <= S_DONE;
          r_busy   <= 1'b0;
          r_preset <= 1'b0;
          r_done   <= 1'b1;
        end
        S_RUN: begin
          r_steps <= r_steps - 8'd1;
          if (w_wrap) r_wrapped <= 1'b1;
          if (abort || r_steps == 8'd1) begin
            r_aborted <= abort;
            r_state   <= S_DONE;
            r_busy    <= 1'b0;
            r_preset  <= 1'b0;
            r_done    <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready   = r_ready;
  assign busy        = r_busy;
  assign done        = r_done;
  assign bank_preset = r_preset;
  assign wrapped     = r_wrapped;
  assign aborted     = r_aborted;
  assign steps_left  = r_steps;
  assign jack        = (r_state == S_RUN) ? w_t : r_ej;
  assign kilby       = (r_state == S_RUN) ? w_t : r_ek;

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Bench for jk_bank_sequencer: a behavioural JK bank closes the loop, a
// vector table covers the directed cases, random commands hit a count model.
module tb_jk_bank_sequencer;
  localparam int W = 4;

  logic         clockpulse = 1'b0;
  logic         clear, cmd_valid, abort;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_data, q, jack, kilby;
  logic [7:0]   cmd_count, steps_left;
  logic         cmd_ready, bank_preset, busy, done, wrapped, aborted;

  int total = 0;
  int bad   = 0;
  int mq    = 0;

  jk_bank_sequencer #(.WIDTH(W)) dut (
    .clockpulse(clockpulse), .clear(clear), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .cmd_count(cmd_count), .abort(abort), .q(q), .jack(jack), .kilby(kilby),
    .bank_preset(bank_preset), .busy(busy), .done(done), .wrapped(wrapped),
    .aborted(aborted), .steps_left(steps_left)
  );

  always #5 clockpulse = ~clockpulse;

  always_ff @(posedge clockpulse or posedge clear) begin
    if (clear) q <= '0;
    else if (bank_preset)
      for (int i = 0; i < W; i++)
        case ({jack[i], kilby[i]})
          2'b10:   q[i] <= 1'b1;
          2'b01:   q[i] <= 1'b0;
          2'b11:   q[i] <= ~q[i];
          default: ;
        endcase
  end

  task automatic chk(input string n, input int a, input int e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", n, a, e);
    end
  endtask

  // Counter model in plain modular arithmetic on the bench's copy of q.
  task automatic model(input int op, input int d, input int n, input int ab,
                       output int eq, output int ew, output int ea,
                       output int esl, output int elat, output int epre);
    int steps;
    ew = 0; ea = 0; esl = 0;
    if (op == 0 || op == 3) begin
      mq   = (op == 0) ? d : (mq ^ d);
      elat = 2; epre = 1;
    end else if (n == 0) begin
      elat = 1; epre = 0;
    end else begin
      steps = (ab != 0 && ab <= n) ? ab : n;
      for (int s = 0; s < steps; s++) begin
        if (op == 1) begin
          if (mq == 15) ew = 1;
          mq = (mq + 1) % 16;
        end else begin
          if (mq == 0) ew = 1;
          mq = (mq + 15) % 16;
        end
      end
      ea = (steps < n || ab == n) ? 1 : 0;
      esl = n - steps; elat = steps + 1; epre = steps;
    end
    eq = mq;
  endtask

  task automatic run(input int op, input int d, input int n, input int ab,
                     output int lat, output int pre, output int j1, output int k1);
    int c;
    logic [W-1:0] dv;
    logic [31:0]  nv;
    dv = d[W-1:0];
    nv = n;
    @(negedge clockpulse);
    c = 0;
    while (!cmd_ready && c < 50) begin @(negedge clockpulse); c++; end
    cmd_valid = 1'b1; cmd_op = op[1:0]; cmd_data = dv; cmd_count = nv[7:0];
    @(negedge clockpulse);
    cmd_valid = 1'b0;
    c = 1; pre = 0; lat = -1; j1 = int'(jack); k1 = int'(kilby);
    while (c < 300) begin
      if (bank_preset) pre++;
      if (done) begin lat = c; break; end
      abort = (c == ab);
      @(negedge clockpulse);
      c++;
    end
    abort = 1'b0;
    if (lat < 0) chk("done_timeout", lat, 0);
  endtask

  typedef struct {
    int op; int d; int n; int ab;
    int eq; int ew; int ea; int esl; int elat; int epre;
  } vec_t;

  vec_t tbl[10];
  int lat, pre, j1, k1, eq, ew, ea, esl, elat, epre, nd;

  task automatic check_result(input string tag, input int op, input int d);
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_q"}, int'(q), eq);
    chk({tag, "_wrapped"}, int'(wrapped), ew);
    chk({tag, "_aborted"}, int'(aborted), ea);
    chk({tag, "_preset_cycles"}, pre, epre);
    if (op == 1 || op == 2) chk({tag, "_steps_left"}, int'(steps_left), esl);
    if (op == 0) begin
      chk({tag, "_jack"}, j1, d);
      chk({tag, "_kilby"}, k1, (~d) & 15);
    end
    if (op == 3) chk({tag, "_jk_mask"}, j1 + 16 * k1, d + 16 * d);
  endtask

  initial begin
    tbl[0] = '{0, 10, 0,   0, 10, 0, 0,   0, 2, 1};
    tbl[1] = '{0, 13, 0,   0, 13, 0, 0,   0, 2, 1};
    tbl[2] = '{1,  0, 5,   0,  2, 1, 0,   0, 6, 5};
    tbl[3] = '{0,  0, 0,   0,  0, 0, 0,   0, 2, 1};
    tbl[4] = '{2,  0, 1,   0, 15, 1, 0,   0, 2, 1};
    tbl[5] = '{2,  0, 0,   0, 15, 0, 0,   0, 1, 0};
    tbl[6] = '{0, 10, 0,   0, 10, 0, 0,   0, 2, 1};
    tbl[7] = '{3,  6, 0,   0, 12, 0, 0,   0, 2, 1};
    tbl[8] = '{0,  0, 0,   0,  0, 0, 0,   0, 2, 1};
    tbl[9] = '{1,  0, 200, 3,  3, 0, 1, 197, 4, 3};

    clear = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
    cmd_op = '0; cmd_data = '0; cmd_count = '0;
    repeat (2) @(negedge clockpulse);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_busy_done", int'({busy, done, bank_preset}), 0);
    chk("rst_jk", int'({jack, kilby}), 0);
    chk("rst_status", int'({wrapped, aborted}), 0);
    chk("rst_steps_left", int'(steps_left), 0);
    clear = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run(tbl[i].op, tbl[i].d, tbl[i].n, tbl[i].ab, lat, pre, j1, k1);
      eq = tbl[i].eq; ew = tbl[i].ew; ea = tbl[i].ea; esl = tbl[i].esl;
      elat = tbl[i].elat; epre = tbl[i].epre;
      check_result($sformatf("vec%0d", i), tbl[i].op, tbl[i].d);
    end
    mq = 3;

    // cmd_valid held high across two UP 3 commands: second accept only after DONE.
    @(negedge clockpulse);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = '0; cmd_count = 8'd3;
    nd = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clockpulse);
      if (c == 9) cmd_valid = 1'b0;
      if (done) begin
        nd++;
        chk($sformatf("hs_done_cycle%0d", nd), c, (nd == 1) ? 4 : 9);
        chk("hs_ready_in_done", int'(cmd_ready), 0);
      end
      if (c <= 3) chk("hs_busy", int'(busy), 1);
    end
    chk("hs_done_count", nd, 2);
    chk("hs_q", int'(q), 9);
    mq = 9;

    // Clear in the middle of an UP run.
    run(0, 5, 0, 0, lat, pre, j1, k1);
    @(negedge clockpulse);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = '0; cmd_count = 8'd100;
    @(negedge clockpulse);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clockpulse);
    chk("clr_pre_busy", int'(busy), 1);
    chk("clr_pre_q", int'(q), 8);
    clear = 1'b1;
    #1;
    chk("clr_q", int'(q), 0);
    chk("clr_ready", int'(cmd_ready), 1);
    chk("clr_busy_preset", int'({busy, bank_preset, done}), 0);
    chk("clr_steps_left", int'(steps_left), 0);
    @(negedge clockpulse);
    clear = 1'b0;
    nd = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clockpulse);
      if (done) nd++;
    end
    chk("clr_no_done", nd, 0);
    chk("clr_q_hold", int'(q), 0);
    mq = 0;

    for (int i = 0; i < 40; i++) begin
      int op, d, n, ab;
      op = $urandom_range(0, 3);
      d  = $urandom_range(0, 15);
      n  = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 20);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 25) : 0;
      run(op, d, n, ab, lat, pre, j1, k1);
      model(op, d, n, ab, eq, ew, ea, esl, elat, epre);
      check_result($sformatf("rnd%0d", i), op, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/jk_bank_sequencer.md
# jk_bank_sequencer

Command-driven controller that sequences a bank of WIDTH external JK flip-flops, one per bit, as a loadable, toggleable up/down counter. It accepts one command at a time over a valid/ready handshake and drives the bank's per-bit J/K inputs and update enable each clock. It reads the bank outputs back on `q`, and reports completion, remaining steps and wrap-around. It sits between the lab's command source (switches or a test sequencer) and the JK flip-flop bank.

## Interface
- `WIDTH`, default 4: number of JK flip-flops in the bank. Legal range 2..16.
- `clockpulse`  in  1  the single clock. All state changes on the rising edge; the bank shares this clock.
- `clear`  in  1  reset, asynchronous and active-high. It is tied to the bank's clear input as well.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller can accept a command. High only in IDLE.
- `cmd_op`  in  2  opcode: 00 LOAD, 01 UP, 10 DOWN, 11 TOGGLE.
- `cmd_data`  in  WIDTH  value for LOAD; bit mask for TOGGLE.
- `cmd_count`  in  8  number of steps for UP/DOWN, 0..255.
- `abort`  in  1  synchronous request to stop an UP/DOWN run early.
- `q`  in  WIDTH  registered outputs of the bank, fed back.
- `jack`  out  WIDTH  per-bit J to the bank.
- `kilby`  out  WIDTH  per-bit K to the bank.
- `bank_preset`  out  1  bank update enable. Low forces the bank to hold.
- `busy`  out  1  high in EXEC and RUN.
- `done`  out  1  one-cycle completion pulse.
- `wrapped`  out  1  the last command wrapped the count.
- `aborted`  out  1  the last command ended by `abort`.
- `steps_left`  out  8  remaining UP/DOWN steps, including the current one.

## Operation
- FSM states are IDLE, EXEC, RUN and DONE.
- **Accept.** A command is accepted on an edge where `cmd_valid & cmd_ready`. Op, data and count are latched; `wrapped` and `aborted` clear on the same edge.
  - LOAD or TOGGLE: go to EXEC.
  - UP or DOWN with count > 0: go to RUN, `steps_left` = count.
  - UP or DOWN with count = 0: go to DONE with no bank update.
- **EXEC** lasts 1 cycle, then goes to DONE.
  - LOAD: `jack` = data, `kilby` = ~data.
  - TOGGLE: `jack` = `kilby` = mask. Bits with mask 0 hold.
- **RUN** issues one step per cycle; `jack` = `kilby` = t, combinational from `q`.
  - UP: t[0] = 1; t[i] = &q[i-1:0].
  - DOWN: t[0] = 1; t[i] = ~|q[i-1:0].
  - Arithmetic is modulo 2^WIDTH.
  - Wrap condition: a step taken when UP and q = all ones, or when DOWN and q = 0. When it occurs, set the sticky `wrapped`.
  - `steps_left` decrements each RUN edge. When a step is taken with `steps_left` = 1, go to DONE.
  - `abort` high in a RUN cycle: that cycle's step still happens, then go to DONE with `aborted` = 1.
- **DONE** lasts 1 cycle with `done` = 1, then returns to IDLE. `cmd_ready` is low in DONE, so back-to-back commands are spaced by at least one DONE cycle.
- **Idle outputs.** In IDLE and DONE: `jack` = `kilby` = 0 and `bank_preset` = 0.
- **bank_preset** is high in EXEC and RUN only.
- **Ignored inputs.** `abort` is ignored in IDLE, EXEC and DONE. `cmd_valid` outside IDLE is ignored; the source must hold the command until ready.
- **Reset.** `clear` asserted in any state, including mid-RUN: immediate return to IDLE, the bank clears to 0, and no `done` pulse.

## Timing
- Reset values:
  - state IDLE, so `cmd_ready` = 1;
  - `jack` = `kilby` = 0, `bank_preset` = 0;
  - `busy` = `done` = `wrapped` = `aborted` = 0, `steps_left` = 0.
- Command accepted at edge E0:
  - EXEC or RUN starts in the cycle after E0.
  - The bank updates at edge E1, and `q` reflects the result after E1.
- LOAD/TOGGLE: `done` is high in the cycle after E1, with `q` already showing the final value. Acceptance to `done` = 2 cycles.
- UP/DOWN with count N > 0: N RUN cycles, then `done` in cycle N+1 after E0. The final `q` is valid when `done` is high.
- Count 0: `done` in the cycle after E0; `q` unchanged.
- Abort seen in RUN cycle k: k steps are taken in total, and `done` is high in cycle k+1. `steps_left` at `done` = N−k.
- `wrapped` and `aborted` are valid from `done` until the next accept.

## Test plan
- **Reset then LOAD.** Reset, then LOAD data = 4'b1010 (WIDTH = 4) → `jack` = 1010 and `kilby` = 0101 for 1 cycle; `done` 2 cycles after accept; `q` = 1010; `wrapped` = 0.
- **UP with wrap.** LOAD 4'b1101, then UP count 5 → q steps 1110, 1111, 0000, 0001, 0010; `done` 6 cycles after accept; `wrapped` = 1; `steps_left` = 0.
- **DOWN from zero.** LOAD 0, then DOWN count 1 → q = 1111, `wrapped` = 1.
- **Count 0.** DOWN count 0 → `done` the next cycle, `q` unchanged, `bank_preset` never high.
- **TOGGLE and handshake.** TOGGLE mask 0110 on q = 1010 → q = 1100. `cmd_valid` held through busy is not accepted until IDLE; `cmd_ready` is low in DONE.
- **Abort and reset.** UP count 200 from 0, `abort` in RUN cycle 3 → q = 3, `aborted` = 1, `steps_left` = 197 at `done`. Separately, `clear` mid-RUN → IDLE at once, q = 0, no `done`.
